matrix_row_scanner: RTL
=======================

// Module: matrix_row_scanner
// PURPOSE
//  Time-multiplexes a 7-row x 5-column LED dot matrix. Consumes the seven
//  5-bit column patterns produced by the modulo_preset_linha_1..7 stages
//  (cl1..cl7). Drives one row at a time, with a blanking gap between rows.
//  Snapshots all patterns at each frame start, so a preset change never tears a frame.
// PARAMETERS
//  ROW_CYCLES  8     clk cycles per row slot, blank + drive; legal 2..65535
//  BLANK       1     cycles of blanking at start of each slot; 1..ROW_CYCLES-1
//  COL_ACT_LOW 1     1: col_out active-low (bit=0 lights LED); 0: active-high
//  ROW_ACT_LOW 1     1: row_out active-low (selected row=0); 0: active-high
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous, active-low reset
//  en           in   1   scan enable; 0 forces display off
//  cl1..cl7     in   5   column pattern per row (bit4=leftmost), 1 = LED on
//  col_out      out  5   column drive to matrix (polarity per COL_ACT_LOW)
//  row_out      out  7   row select, one-hot when driving (polarity per ROW_ACT_LOW)
//  row_idx      out  3   index of row in current slot, 0..6
//  frame_start  out  1   1-cycle pulse on first cycle of row 0 slot
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, slot counter=0, row_idx=0.
//   Also: snapshot=0, frame_start=0, row_out and col_out all inactive.
//   Inactive levels: row_out=7'h7F and col_out=5'h1F with defaults.
//  All outputs are registered. Outputs reflect state/counters with 1-cycle latency from clk edge.
//  FSM states IDLE, BLANK, DRIVE:
//   IDLE : outputs inactive. en=1 -> BLANK, row_idx=0, slot cnt=0.
//          Same edge: snapshot cl1..cl7 and pulse frame_start.
//   BLANK: row_out and col_out inactive; cnt increments.
//          When cnt==BLANK-1 -> DRIVE.
//   DRIVE: row_out selects row_idx; col_out = snapshot[row_idx], polarity applied.
//          Output is active-high when COL_ACT_LOW=0, inverted when COL_ACT_LOW=1.
//          When cnt==ROW_CYCLES-1: cnt=0 and -> BLANK.
//          row_idx advances 6->0 (wrap). On wrap, re-snapshot and pulse frame_start.
//  Snapshot is taken only at frame start. cl changes mid-frame show on the next frame.
//  en sampled every cycle. en=0 in any state -> IDLE next cycle, outputs inactive next cycle.
//   Counters clear. Re-enable always restarts at row 0 with a fresh snapshot.
//  Never two rows active at once. Row change always passes through >= BLANK inactive cycles.
//  Frame period = 7*ROW_CYCLES cycles exactly. frame_start period identical while en=1.
//  Counter width = $clog2(ROW_CYCLES); no overflow reachable.
//  rst_n asserted mid-slot: outputs inactive immediately (async).
// TESTING
//  (ROW_CYCLES=4, BLANK=1, defaults unless noted)
//  1 Reset: rst_n=0 mid-DRIVE -> same cycle row_out=7'h7F, col_out=5'h1F.
//    After release with en=0, outputs stay inactive and frame_start stays 0.
//  2 Scan order: en=1, cl1=5'h11, cl2..cl7=5'h0E.
//    Row 0 driving: row_out=7'h7E, col_out=5'h0E.
//    Row 1 driving: row_out=7'h7D, col_out=5'h11.
//    Each row: 1 blank cycle, then 3 drive cycles. frame_start every 28 cycles.
//  3 Tear-free: change cl3 from 5'h1F to 5'h00 during row 1 of a frame.
//    Current frame row 2 shows old value (col_out=5'h00 when row 2 drives).
//    Next frame shows new value (col_out=5'h1F).
//  4 Wrap: observe row 6 -> row 0 transition.
//    Exactly 1 cycle where row_out=7'h7F and col_out=5'h1F.
//    frame_start=1 on the first cycle of the row 0 slot.
//  5 Enable abort: en=0 during row 4 DRIVE -> next cycle all inactive.
//    en=1 later -> frame_start pulse, row 0 slot follows. No row 5 emitted.
//  6 Polarity: COL_ACT_LOW=0, ROW_ACT_LOW=0, cl1=5'h15.
//    Row 0 drives: row_out=7'h01, col_out=5'h15.
//    Blank cycles: row_out=7'h00, col_out=5'h00.

Source files
------------

// File: rtl/matrix_row_scanner.sv
// matrix_row_scanner: drives a 7-row x 5-column LED matrix one row at a time.
// Every row slot starts with a blanking gap and then drives that row. The
// column patterns are captured once per frame, so a frame never mixes
// old and new patterns.
module matrix_row_scanner #(
  parameter int ROW_CYCLES  = 8,
  parameter int BLANK       = 1,
  parameter int COL_ACT_LOW = 1,
  parameter int ROW_ACT_LOW = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [4:0] cl1,
  input  logic [4:0] cl2,
  input  logic [4:0] cl3,
  input  logic [4:0] cl4,
  input  logic [4:0] cl5,
  input  logic [4:0] cl6,
  input  logic [4:0] cl7,
  output logic [4:0] col_out,
  output logic [6:0] row_out,
  output logic [2:0] row_idx,
  output logic       frame_start,
  output logic [1:0] fsm_state
);

  localparam int CW = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
  localparam logic [CW-1:0] ROW_LAST   = CW'(ROW_CYCLES - 1);
  localparam logic [6:0] ROW_OFF = (ROW_ACT_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [4:0] COL_OFF = (COL_ACT_LOW != 0) ? 5'h1F : 5'h00;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [6:0][4:0] snap;
  logic [4:0]      cur_pat;

  assign fsm_state = state;

  // Row select with polarity applied (one-hot on the selected row).
  function automatic logic [6:0] row_drive(input logic [2:0] idx);
    logic [6:0] oh;
    oh = 7'd1 << idx;
    return (ROW_ACT_LOW != 0) ? ~oh : oh;
  endfunction

  // Column pattern with polarity applied (pattern bit 1 = LED on).
  function automatic logic [4:0] col_drive(input logic [4:0] pat);
    return (COL_ACT_LOW != 0) ? ~pat : pat;
  endfunction

  // Pattern of the row in the current slot, taken from the frame snapshot.
  always_comb begin
    cur_pat = snap[0];
    case (row_idx)
      3'd1:    cur_pat = snap[1];
      3'd2:    cur_pat = snap[2];
      3'd3:    cur_pat = snap[3];
      3'd4:    cur_pat = snap[4];
      3'd5:    cur_pat = snap[5];
      3'd6:    cur_pat = snap[6];
      default: cur_pat = snap[0];
    endcase
  end

  // Scan FSM; outputs are registered alongside the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      row_idx     <= 3'd0;
      snap        <= '0;
      frame_start <= 1'b0;
      row_out     <= ROW_OFF;
      col_out     <= COL_OFF;
    end else if (!en) begin
      // Disable aborts the frame; re-enable restarts at row 0.
      state       <= S_IDLE;
      cnt         <= '0;
      row_idx     <= 3'd0;
      frame_start <= 1'b0;
      row_out     <= ROW_OFF;
      col_out     <= COL_OFF;
    end else begin
      case (state)
        S_IDLE: begin
          state       <= S_BLANK;
          cnt         <= '0;
          row_idx     <= 3'd0;
          snap        <= {cl7, cl6, cl5, cl4, cl3, cl2, cl1};
          frame_start <= 1'b1;
          row_out     <= ROW_OFF;
          col_out     <= COL_OFF;
        end
        S_BLANK: begin
          frame_start <= 1'b0;
          cnt         <= cnt + 1'b1;
          if (cnt == BLANK_LAST) begin
            state   <= S_DRIVE;
            row_out <= row_drive(row_idx);
            col_out <= col_drive(cur_pat);
          end else begin
            row_out <= ROW_OFF;
            col_out <= COL_OFF;
          end
        end
        S_DRIVE: begin
          frame_start <= 1'b0;
          if (cnt == ROW_LAST) begin
            // End of slot: blank before the next row is ever selected.
            cnt     <= '0;
            state   <= S_BLANK;
            row_out <= ROW_OFF;
            col_out <= COL_OFF;
            if (row_idx == 3'd6) begin
              row_idx     <= 3'd0;
              snap        <= {cl7, cl6, cl5, cl4, cl3, cl2, cl1};
              frame_start <= 1'b1;
            end else begin
              row_idx <= row_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state       <= S_IDLE;
          cnt         <= '0;
          row_idx     <= 3'd0;
          frame_start <= 1'b0;
          row_out     <= ROW_OFF;
          col_out     <= COL_OFF;
        end
      endcase
    end
  end

endmodule
